parking_input_conditioner: RTL and testbench

Front-end conditioning for the parking-lot controller's operator inputs: power key (pow), pay key (pay) and eight slot switches (swt).
- Synchronises and debounces all ten raw board inputs.
- Emits single-cycle key pulses and a stable switch vector.
- Queues per-slot arrival/departure events in a small FIFO with a valid/ready handshake.
- Sits between the board pins and the controller core, which consumes the clean pulses and events.

---
 rtl/parking_input_conditioner.sv | 134 +++++++++++++
 tb/tb_parking_input_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/parking_input_conditioner.sv
// Operator-input front end: 2-flop sync + debounce for pow/pay/swt, key pulses, slot event FIFO.
// Define DEBOUNCE_BYPASS_EN to drop the debounce counters (stable = synchronised input).
module parking_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 18,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pow_in,
  input  logic       pay_in,
  input  logic [7:0] swt_in,
  output logic       pow_pulse,
  output logic       pay_pulse,
  output logic [7:0] swt_stable,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_slot,
  output logic       evt_arrive,
  output logic       evt_lost
);
  localparam int NCH = 10;
  localparam int AW  = $clog2(FIFO_DEPTH);

  // channel map: [0]=pow, [1]=pay, [9:2]=swt
  logic [NCH-1:0] raw, sync1_q, sync2_q, stable_q, stable_d;
  assign raw = {swt_in, pay_in, pow_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  assign stable_d = sync2_q;
`else
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int c = 0; c < NCH; c++) begin
      if (sync2_q[c] == stable_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[c] = sync2_q[c];
        cnt_d[c]    = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // pulses register on the same edge the stable value rises
  logic pow_pulse_q, pow_pulse_d, pay_pulse_q, pay_pulse_d;
  assign pow_pulse_d = stable_d[0] & ~stable_q[0];
  assign pay_pulse_d = stable_d[1] & ~stable_q[1];

  // pending mask / push arbitration
  logic [7:0] swt_q, chg, pend_q, pend_d, push_mask;
  logic [2:0] push_slot;
  logic       push, pop, full, empty, lost_q, lost_d;

  assign swt_q = stable_q[9:2];
  assign chg   = stable_d[9:2] ^ stable_q[9:2];

  always_comb begin
    push_slot = '0;
    push_mask = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) push_slot = 3'(i);
    end
    push = (|pend_q) && (!full || pop);
    if (push) push_mask[push_slot] = 1'b1;
    // a same-cycle re-change of the pushed slot keeps it pending
    pend_d = (pend_q & ~push_mask) | chg;
    lost_d = lost_q | (|(chg & pend_q & ~push_mask));
  end

  // show-ahead FIFO, extra pointer bit distinguishes full from empty
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [3:0]  head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && evt_ready;
  assign wr_d  = push ? wr_q + 1'b1 : wr_q;
  assign rd_d  = pop  ? rd_q + 1'b1 : rd_q;
  assign head  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {push_slot, swt_q[push_slot]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pow_pulse_q <= 1'b0;
      pay_pulse_q <= 1'b0;
      pend_q      <= '0;
      lost_q      <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      pow_pulse_q <= pow_pulse_d;
      pay_pulse_q <= pay_pulse_d;
      pend_q      <= pend_d;
      lost_q      <= lost_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  assign pow_pulse  = pow_pulse_q;
  assign pay_pulse  = pay_pulse_q;
  assign swt_stable = swt_q;
  assign evt_valid  = !empty;
  assign evt_slot   = empty ? 3'd0 : head[3:1];
  assign evt_arrive = empty ? 1'b0 : head[0];
  assign evt_lost   = lost_q;
endmodule

// File: tb/tb_parking_input_conditioner.sv
// Directed stimulus with an event scoreboard; a negedge monitor checks every popped event.
module tb_parking_input_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pow_in = 1'b0, pay_in = 1'b0;
  logic [7:0] swt_in = 8'h00;
  logic       pow_pulse, pay_pulse, evt_valid, evt_ready = 1'b0, evt_arrive, evt_lost;
  logic [7:0] swt_stable;
  logic [2:0] evt_slot;

  int n_cmp = 0, n_err = 0;
  int pow_cnt = 0, pay_cnt = 0;
  logic [3:0] exp_q[$];

  parking_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pow_in(pow_in), .pay_in(pay_in), .swt_in(swt_in),
    .pow_pulse(pow_pulse), .pay_pulse(pay_pulse), .swt_stable(swt_stable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_slot(evt_slot),
    .evt_arrive(evt_arrive), .evt_lost(evt_lost)
  );

  always #5 clk = ~clk;

  // monitor: pops and compares on every accepted event
  always @(negedge clk) begin
    if (!rst) begin
      if (pow_pulse) pow_cnt++;
      if (pay_pulse) pay_cnt++;
      if (evt_valid && evt_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL evt_unexpected: got slot=%0d arrive=%0b, required none", evt_slot, evt_arrive);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if ({evt_slot, evt_arrive} !== e) begin
            n_err++;
            $display("FAIL evt: got slot=%0d arrive=%0b, required slot=%0d arrive=%0b",
                     evt_slot, evt_arrive, e[3:1], e[0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset / idle
    rst = 1'b1;
    hold(3);
    chk("rst_pow_pulse", pow_pulse, 0);
    chk("rst_pay_pulse", pay_pulse, 0);
    chk("rst_swt_stable", swt_stable, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_slot", evt_slot, 0);
    chk("rst_evt_arrive", evt_arrive, 0);
    chk("rst_evt_lost", evt_lost, 0);
    rst = 1'b0;
    hold(2);

    // pow debounce: pulse exactly after edge 6
    pow_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("pow_pulse_e%0d", k), pow_pulse, (k == 6) ? 1 : 0);
    end
    chk("pow_swt_unaffected", swt_stable, 0);
    pow_in = 1'b0;
    hold(10);
    chk("pow_fall_nopulse", pow_cnt, 1);
    // glitch of 3 cycles must be filtered
    pow_in = 1'b1;
    hold(3);
    pow_in = 1'b0;
    hold(12);
    chk("pow_glitch", pow_cnt, 1);

    // pay held long: single pulse, none on release
    pay_in = 1'b1;
    hold(50);
    pay_in = 1'b0;
    hold(15);
    chk("pay_hold", pay_cnt, 1);

    // arrival / departure
    evt_ready = 1'b1;
    swt_in = 8'h01;
    exp_q.push_back({3'd0, 1'b1});
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("arr_stable_e5", swt_stable, 8'h00);
      if (k == 6) chk("arr_stable_e6", swt_stable, 8'h01);
    end
    wait_drain(20);
    swt_in = 8'h00;
    exp_q.push_back({3'd0, 1'b0});
    wait_drain(20);
    chk("dep_stable", swt_stable, 8'h00);

    // simultaneous arrivals under backpressure
    evt_ready = 1'b0;
    swt_in = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 1'b1});
    hold(15);
    chk("bp_valid", evt_valid, 1);
    chk("bp_head_slot", evt_slot, 0);
    chk("bp_head_arrive", evt_arrive, 1);
    chk("bp_lost", evt_lost, 0);
    evt_ready = 1'b1;
    wait_drain(40);
    chk("bp_after_lost", evt_lost, 0);
    chk("bp_stable", swt_stable, 8'hFF);

    // lost: slot 7 toggles twice while pending behind a full FIFO
    evt_ready = 1'b0;
    swt_in = 8'h00;
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 1'b0});
    hold(12);
    chk("lost_pre", evt_lost, 0);
    swt_in = 8'h80;
    hold(12);
    chk("lost_set", evt_lost, 1);
    swt_in = 8'h00;
    hold(12);
    evt_ready = 1'b1;
    wait_drain(40);
    chk("lost_sticky", evt_lost, 1);

    // reset mid-stream discards queued events; held inputs re-appear as arrivals
    evt_ready = 1'b0;
    swt_in = 8'hFF;
    hold(15);
    chk("mid_valid_before_rst", evt_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_lost", evt_lost, 0);
    chk("mid_rst_stable", swt_stable, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 1'b1});
    tick();
    chk("post_rst_lost", evt_lost, 0);
    evt_ready = 1'b1;
    wait_drain(60);
    chk("post_rst_stable", swt_stable, 8'hFF);
    chk("post_rst_valid", evt_valid, 0);
    chk("post_rst_lost2", evt_lost, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
